// File: rtl/space_inv_pkg.sv
// Shared constants and encodings for the space-invaders style game blocks.
// Holds the player-shot state encoding and the screen geometry defaults.
package space_inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_COOLDOWN = 2'd2
    } shot_state_t;

    localparam int SCREEN_H     = 480;
    localparam int SCREEN_W     = 640;
    localparam int DEF_START_Y  = 440;
    localparam int DEF_X_OFFSET = 8;

endpackage

// File: rtl/btn_rise_detect.sv
// Registered rising-edge detector, one lane per button bit.
// The history register resets high so a button held through reset does not fire.
module btn_rise_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn,
    output logic [W-1:0] rise
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            logic btn_q_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    btn_q_reg <= 1'b1;
                end else begin
                    btn_q_reg <= btn[gi];
                end
            end

            assign rise[gi] = btn[gi] & ~btn_q_reg;
        end
    endgenerate

endmodule

// File: rtl/player_shot_ctrl.sv
// Player projectile controller: one shot at a time, launched on a fire-button
// rising edge, climbing once per frame, retired by hit or screen top, then cooldown.
module player_shot_ctrl
    import space_inv_pkg::*;
#(
    parameter int X_W             = 10,
    parameter int Y_W             = 10,
    parameter int X_OFFSET        = DEF_X_OFFSET,
    parameter int START_Y         = DEF_START_Y,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fire_btn,
    input  logic [X_W-1:0] player_x,
    input  logic           move_tick,
    input  logic           hit,
    output logic           shot_active,
    output logic [X_W-1:0] shot_x,
    output logic [Y_W-1:0] shot_y,
    output logic           shot_fired,
    output logic           ready
);

    // Counter is kept one bit wide when cooldown is disabled so it never vanishes.
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic fire_rise;

    shot_state_t    state_reg,  state_next;
    logic           active_reg, active_next;
    logic [X_W-1:0] x_reg,      x_next;
    logic [Y_W-1:0] y_reg,      y_next;
    logic           fired_reg,  fired_next;
    logic           ready_reg,  ready_next;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;

    btn_rise_detect #(
        .W (1)
    ) u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (fire_btn),
        .rise  (fire_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            active_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            fired_reg  <= 1'b0;
            ready_reg  <= 1'b1;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            fired_reg  <= fired_next;
            ready_reg  <= ready_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        fired_next  = 1'b0;
        cnt_next    = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (fire_rise) begin
                    state_next  = ST_FLY;
                    active_next = 1'b1;
                    x_next      = player_x + X_W'(X_OFFSET);
                    y_next      = Y_W'(START_Y);
                    fired_next  = 1'b1;
                end
            end

            ST_FLY: begin
                // A hit wins over the frame step; position freezes where it was.
                if (hit || (move_tick && (y_reg < Y_W'(SPEED)))) begin
                    active_next = 1'b0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_COOLDOWN;
                        cnt_next   = CNT_W'(COOLDOWN_FRAMES);
                    end
                end else if (move_tick) begin
                    y_next = y_reg - Y_W'(SPEED);
                end
            end

            ST_COOLDOWN: begin
                if (move_tick) begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next  = ST_IDLE;
                active_next = 1'b0;
                cnt_next    = '0;
            end
        endcase

        ready_next = (state_next == ST_IDLE);
    end

    assign shot_active = active_reg;
    assign shot_x      = x_reg;
    assign shot_y      = y_reg;
    assign shot_fired  = fired_reg;
    assign ready       = ready_reg;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Self-checking bench for player_shot_ctrl: vector table, hand-built corner
// sequences, and random stimulus against a behavioural shot model.
module tb_player_shot_ctrl;

    localparam int XOFF = 8;
    localparam int SY   = 440;
    localparam int SPD  = 4;
    localparam int CD   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire_btn, move_tick, hit;
    logic [9:0] player_x;
    logic       shot_active, shot_fired, ready;
    logic [9:0] shot_x, shot_y;

    logic       z_fire, z_tick, z_hit;
    logic [9:0] z_px;
    logic       z_active, z_fired, z_ready;
    logic [9:0] z_x, z_y;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a shot is either flying, cooling down, or absent.
    bit m_active, m_fired, m_prev;
    int m_x, m_y, m_cool;

    typedef struct {
        bit f; int px; bit t; bit h;
        bit e_active; int e_x; int e_y; bit e_fired; bit e_ready;
    } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    player_shot_ctrl dut (
        .clk(clk), .reset(reset), .fire_btn(fire_btn), .player_x(player_x),
        .move_tick(move_tick), .hit(hit), .shot_active(shot_active),
        .shot_x(shot_x), .shot_y(shot_y), .shot_fired(shot_fired), .ready(ready)
    );

    player_shot_ctrl #(.COOLDOWN_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .fire_btn(z_fire), .player_x(z_px),
        .move_tick(z_tick), .hit(z_hit), .shot_active(z_active),
        .shot_x(z_x), .shot_y(z_y), .shot_fired(z_fired), .ready(z_ready)
    );

    function automatic vec_t mk(bit f, int px, bit t, bit h,
                                bit ea, int ex, int ey, bit ef, bit er);
        vec_t v;
        v.f = f; v.px = px; v.t = t; v.h = h;
        v.e_active = ea; v.e_x = ex; v.e_y = ey; v.e_fired = ef; v.e_ready = er;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_fired = 0; m_prev = 1;
        m_x = 0; m_y = 0; m_cool = 0;
    endtask

    task automatic model_step(bit f, int px, bit t, bit h);
        bit rise;
        rise    = f && !m_prev;
        m_prev  = f;
        m_fired = 0;
        if (m_active) begin
            if (h || (t && m_y < SPD)) begin
                m_active = 0;
                m_cool   = CD;
            end else if (t) begin
                m_y = m_y - SPD;
            end
        end else if (m_cool > 0) begin
            if (t) m_cool = m_cool - 1;
        end else if (rise) begin
            m_active = 1;
            m_fired  = 1;
            m_x      = (px + XOFF) % 1024;
            m_y      = SY;
        end
    endtask

    task automatic cmp_model(string tag);
        bit m_ready;
        m_ready = !m_active && (m_cool == 0);
        checks++;
        if (shot_active !== m_active || shot_fired !== m_fired || ready !== m_ready ||
            shot_x !== 10'(m_x) || shot_y !== 10'(m_y)) begin
            errors++;
            $display("FAIL %s: got act=%0b x=%0d y=%0d fired=%0b rdy=%0b expected act=%0b x=%0d y=%0d fired=%0b rdy=%0b",
                     tag, shot_active, shot_x, shot_y, shot_fired, ready,
                     m_active, m_x, m_y, m_fired, m_ready);
        end
    endtask

    task automatic step(bit f, int px, bit t, bit h, bit do_cmp, string tag);
        fire_btn = f; player_x = 10'(px); move_tick = t; hit = h;
        @(posedge clk);
        model_step(f, px, t, h);
        #1;
        if (do_cmp) cmp_model(tag);
    endtask

    task automatic do_reset(bit f);
        fire_btn = f; move_tick = 0; hit = 0; player_x = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_model("reset_state");
        reset = 0;
    endtask

    task automatic z_step(bit f, bit t, bit h);
        z_fire = f; z_tick = t; z_hit = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        z_fire = 0; z_tick = 0; z_hit = 0; z_px = 10'd50;

        // Button held through reset release must never fire.
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(1, 100, 0, 0, 1, "held_through_reset");
            check("held_no_fire", shot_fired, 0);
        end
        $display("held-through-reset: 20 cycles, fired=%0b rdy=%0b", shot_fired, ready);

        vecs[0]  = mk(0, 100, 0, 0,  0, 0,   0,   0, 1);
        vecs[1]  = mk(1, 100, 0, 0,  1, 108, 440, 1, 0);
        vecs[2]  = mk(1, 200, 1, 0,  1, 108, 436, 0, 0);
        vecs[3]  = mk(0, 200, 0, 0,  1, 108, 436, 0, 0);
        vecs[4]  = mk(1, 200, 0, 0,  1, 108, 436, 0, 0);
        vecs[5]  = mk(0, 200, 1, 0,  1, 108, 432, 0, 0);
        vecs[6]  = mk(0, 200, 1, 1,  0, 108, 432, 0, 0);
        vecs[7]  = mk(1, 200, 1, 0,  0, 108, 432, 0, 0);
        for (int i = 8; i < 14; i++) vecs[i] = mk(0, 200, 1, 0, 0, 108, 432, 0, 0);
        vecs[14] = mk(1, 200, 1, 0,  0, 108, 432, 0, 1);
        vecs[15] = mk(1, 200, 0, 0,  0, 108, 432, 0, 1);
        vecs[16] = mk(0, 200, 0, 0,  0, 108, 432, 0, 1);
        vecs[17] = mk(1, 1020, 0, 0, 1, 4,   440, 1, 0);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].f, vecs[i].px, vecs[i].t, vecs[i].h, 0, "");
            checks++;
            if (shot_active !== vecs[i].e_active || shot_x !== 10'(vecs[i].e_x) ||
                shot_y !== 10'(vecs[i].e_y) || shot_fired !== vecs[i].e_fired ||
                ready !== vecs[i].e_ready) begin
                errors++;
                $display("FAIL vec%0d: got act=%0b x=%0d y=%0d fired=%0b rdy=%0b expected act=%0b x=%0d y=%0d fired=%0b rdy=%0b",
                         i, shot_active, shot_x, shot_y, shot_fired, ready,
                         vecs[i].e_active, vecs[i].e_x, vecs[i].e_y, vecs[i].e_fired, vecs[i].e_ready);
            end else begin
                $display("vec%0d: act=%0b x=%0d y=%0d fired=%0b rdy=%0b",
                         i, shot_active, shot_x, shot_y, shot_fired, ready);
            end
        end

        // Climb to the top row, then expire on the following tick.
        for (int i = 0; i < 110; i++) step(0, 0, 1, 0, 1, "climb");
        check("top_y", shot_y, 0);
        check("top_active", shot_active, 1);
        step(0, 0, 1, 0, 1, "expire");
        check("expire_active", shot_active, 0);
        check("expire_ready", ready, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1, "cooldown");
        check("cool_not_ready", ready, 0);
        step(0, 0, 1, 0, 1, "cooldown_end");
        check("cool_ready", ready, 1);
        $display("expire: y reached 0, cooldown done rdy=%0b", ready);

        // Hit and tick together at y=400: hit wins, position freezes.
        step(1, 300, 0, 0, 1, "launch2");
        check("launch2_fired", shot_fired, 1);
        for (int i = 0; i < 10; i++) step(0, 300, 1, 0, 1, "climb2");
        check("y400", shot_y, 400);
        step(0, 300, 1, 1, 1, "hit_tick");
        check("hit_active", shot_active, 0);
        check("hit_y_hold", shot_y, 400);
        check("hit_cool", ready, 0);
        for (int i = 0; i < 8; i++) step(0, 300, 1, 0, 1, "cool2");
        $display("hit+tick: act=%0b y=%0d", shot_active, shot_y);

        // Random traffic against the model.
        begin
            bit f;
            f = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) f = !f;
                step(f, int'($urandom_range(0, 1023)), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 19) == 0), 1, "random");
                if (shot_fired) $display("random shot: x=%0d y=%0d", shot_x, shot_y);
            end
        end
        for (int i = 0; i < 200; i++) step(0, 0, 1, 0, 1, "drain");

        // Reset while a shot has just launched clears it without a pulse.
        step(1, 40, 0, 0, 1, "pre_reset_launch");
        check("pre_reset_fired", shot_fired, 1);
        #2;
        reset = 1;
        #1;
        check("rst_mid_active", shot_active, 0);
        check("rst_mid_fired", shot_fired, 0);
        check("rst_mid_ready", ready, 1);
        model_reset();
        fire_btn = 0;
        @(posedge clk);
        #1;
        reset = 0;
        step(0, 0, 0, 0, 1, "post_reset");
        $display("reset mid-flight: act=%0b fired=%0b", shot_active, shot_fired);

        // Zero-cooldown build: re-armed immediately after a hit.
        z_step(0, 0, 0);
        z_step(1, 0, 0);
        check("z_launch_fired", z_fired, 1);
        check("z_launch_x", z_x, 58);
        check("z_launch_ready", z_ready, 0);
        z_step(0, 0, 1);
        check("z_hit_active", z_active, 0);
        check("z_hit_ready", z_ready, 1);
        z_step(0, 0, 0);
        z_step(1, 0, 0);
        check("z_refire", z_fired, 1);
        check("z_refire_active", z_active, 1);
        $display("zero-cooldown: refire fired=%0b", z_fired);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
